// File: rtl/conway_pkg.sv
// conway_pkg: shared rule constants, cell type and next-state rule for the Game of Life cell
package conway_pkg;
    localparam int NEIGHBOR_COUNT_W = 4;
    localparam logic [NEIGHBOR_COUNT_W-1:0] BIRTH_COUNT = 4'd3;
    localparam logic [NEIGHBOR_COUNT_W-1:0] SURVIVE_COUNT = 4'd2;

    typedef logic cell_t;
    typedef logic [NEIGHBOR_COUNT_W-1:0] count_t;

    function automatic cell_t conway_next(cell_t s, count_t c);
        return (c == BIRTH_COUNT) | (s & (c == SURVIVE_COUNT));
    endfunction
endpackage

// File: rtl/conway_cell_if.sv
// conway_cell_if: strobe/preset/neighbour inputs and state/flag outputs of one cell
import conway_pkg::*;

interface conway_cell_if #(parameter int AGE_W = 4);
    logic             ena;
    logic             load;
    cell_t            load_value;
    logic [7:0]       neighbors;
    count_t           neighbor_count;
    cell_t            state;
    logic [AGE_W-1:0] age;
    logic             stable;
    logic             oscillating;

    modport master (
        output ena, load, load_value, neighbors,
        input  neighbor_count, state, age, stable, oscillating
    );
    modport slave (
        input  ena, load, load_value, neighbors,
        output neighbor_count, state, age, stable, oscillating
    );
endinterface

// File: rtl/conway_cell_neighbor_counter.sv
// neighbor_counter: combinational 8-bit popcount from full adders (3:2 tree, then ripple)
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module neighbor_counter
    import conway_pkg::*;
(
    input  logic [7:0] neighbors_i,
    output count_t     count_o
);
    logic s0, c0, s1, c1, s2, c2, s3, c3, k0, k1;

    // Tree: reduce to one weight-1 pair, one weight-2 bit and one weight-4 bit.
    full_adder u_fa0 (.a_i(neighbors_i[0]), .b_i(neighbors_i[1]), .c_i(neighbors_i[2]), .s_o(s0), .c_o(c0));
    full_adder u_fa1 (.a_i(neighbors_i[3]), .b_i(neighbors_i[4]), .c_i(neighbors_i[5]), .s_o(s1), .c_o(c1));
    full_adder u_fa2 (.a_i(s0), .b_i(s1), .c_i(neighbors_i[6]), .s_o(s2), .c_o(c2));
    full_adder u_fa3 (.a_i(c0), .b_i(c1), .c_i(c2), .s_o(s3), .c_o(c3));

    full_adder u_rc0 (.a_i(s2), .b_i(neighbors_i[7]), .c_i(1'b0), .s_o(count_o[0]), .c_o(k0));
    full_adder u_rc1 (.a_i(s3), .b_i(k0), .c_i(1'b0), .s_o(count_o[1]), .c_o(k1));
    full_adder u_rc2 (.a_i(c3), .b_i(k1), .c_i(1'b0), .s_o(count_o[2]), .c_o(count_o[3]));
endmodule

// File: rtl/conway_cell.sv
// conway_cell: one Game of Life cell with change tracking and period-2 detection.
// Define CONWAY_CELL_AGE_EN to build the saturating age counter; otherwise age reads 0.
module conway_cell
    import conway_pkg::*;
#(
    parameter int AGE_W = 4
) (
    input logic         clk,
    input logic         rst,
    conway_cell_if.slave bus
);
    count_t cnt;
    cell_t  nxt, state_q, state_d;
    logic   changed, stable_q, stable_d, osc_q, osc_d, chg_q, chg_d;

    neighbor_counter u_cnt (.neighbors_i(bus.neighbors), .count_o(cnt));

    always_comb begin
        nxt      = conway_next(state_q, cnt);
        changed  = nxt != state_q;
        state_d  = bus.load ? bus.load_value : bus.ena ? nxt : state_q;
        stable_d = bus.load ? 1'b0 : bus.ena ? !changed : stable_q;
        osc_d    = bus.load ? 1'b0 : bus.ena ? (changed & chg_q) : osc_q;
        chg_d    = bus.load ? 1'b0 : bus.ena ? changed : chg_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= 1'b0;
            stable_q <= 1'b0;
            osc_q    <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            osc_q    <= osc_d;
            chg_q    <= chg_d;
        end
    end

`ifdef CONWAY_CELL_AGE_EN
    logic [AGE_W-1:0] age_q, age_d;

    always_comb
        age_d = bus.load ? '0 : !bus.ena ? age_q : changed ? '0 : (&age_q) ? age_q : age_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) age_q <= '0;
        else      age_q <= age_d;
    end

    assign bus.age = age_q;
`else
    assign bus.age = '0;
`endif

    assign bus.neighbor_count = cnt;
    assign bus.state          = state_q;
    assign bus.stable         = stable_q;
    assign bus.oscillating    = osc_q;
endmodule

// File: tb/tb_conway_cell.sv
// tb_conway_cell: directed vectors feed an expectation queue; a monitor pops and compares.
module tb_conway_cell;
    import conway_pkg::*;

    localparam int AGE_W = 4;
`ifdef CONWAY_CELL_AGE_EN
    localparam bit AGE_ON = 1'b1;
`else
    localparam bit AGE_ON = 1'b0;
`endif

    typedef struct {
        string            name;
        logic [AGE_W+6:0] exp;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conway_cell_if #(.AGE_W(AGE_W)) bus ();
    conway_cell #(.AGE_W(AGE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    rec_t q[$];
    int total = 0;
    int bad = 0;
    event chk_ev;
    logic [AGE_W+6:0] act;
    assign act = {bus.state, bus.age, bus.stable, bus.oscillating, bus.neighbor_count};

    function automatic void expect_o(string name, logic s, int a, logic st, logic os, logic [3:0] c);
        logic [AGE_W-1:0] ea;
        rec_t r;
        ea = AGE_ON ? a[AGE_W-1:0] : '0;
        r.name = name;
        r.exp = {s, ea, st, os, c};
        q.push_back(r);
    endfunction

    initial begin
        rec_t r;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                r = q.pop_front();
                total++;
                if (act !== r.exp) begin
                    bad++;
                    $display("FAIL %s: got {st,age,stb,osc,cnt}=%b expected %b", r.name, act, r.exp);
                end
            end
        end
    end

    task automatic gen(input logic l, input logic lv, input logic e, input logic [7:0] nb,
                       input string name, input logic s, input int a, input logic st,
                       input logic os, input logic [3:0] c);
        @(negedge clk);
        bus.load = l;
        bus.load_value = lv;
        bus.ena = e;
        bus.neighbors = nb;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.ena = 1'b0;
        expect_o(name, s, a, st, os, c);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ena = 1'b1;
        bus.load = 1'b1;
        bus.load_value = 1'b1;
        bus.neighbors = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        expect_o("reset_hold", 0, 0, 0, 0, 8);
        @(negedge clk);
        bus.ena = 1'b0;
        bus.load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_o("reset_idle", 0, 0, 0, 0, 8);
        @(negedge clk);

        gen(1, 1, 0, 8'h00, "load1", 1, 0, 0, 0, 0);
        gen(0, 0, 1, 8'h03, "survive2", 1, 1, 1, 0, 2);
        gen(1, 0, 0, 8'h00, "load0", 0, 0, 0, 0, 0);
        gen(0, 0, 1, 8'hA4, "birth3", 1, 0, 0, 0, 3);
        gen(1, 0, 0, 8'h00, "load0b", 0, 0, 0, 0, 0);
        gen(0, 0, 1, 8'h07, "osc1", 1, 0, 0, 0, 3);
        gen(0, 0, 1, 8'h00, "osc2", 0, 0, 0, 1, 0);
        gen(0, 0, 1, 8'h70, "osc3", 1, 0, 0, 1, 3);
        gen(0, 0, 1, 8'h00, "osc4", 0, 0, 0, 1, 0);
        gen(0, 0, 0, 8'hFF, "hold", 0, 0, 0, 1, 8);
        gen(0, 0, 1, 8'hFF, "crowd_dead", 0, 1, 1, 0, 8);

        gen(1, 1, 0, 8'h81, "load1b", 1, 0, 0, 0, 2);
        for (int i = 0; i < 20; i++)
            gen(0, 0, 1, 8'h81, "age_sat", 1, (i + 1 > 15) ? 15 : i + 1, 1, 0, 2);
        gen(0, 0, 1, 8'h0E, "survive3", 1, 15, 1, 0, 3);
        gen(0, 0, 1, 8'h0F, "over4", 0, 0, 0, 0, 4);
        gen(0, 0, 1, 8'h07, "rebirth", 1, 0, 0, 1, 3);
        gen(1, 0, 1, 8'h07, "load_wins", 0, 0, 0, 0, 3);

        gen(1, 1, 0, 8'h03, "load1c", 1, 0, 0, 0, 2);
        gen(0, 0, 1, 8'h03, "pre_rst", 1, 1, 1, 0, 2);
        @(negedge clk);
        bus.ena = 1'b1;
        bus.neighbors = 8'h07;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        expect_o("async_rst", 0, 0, 0, 0, 3);
        ->chk_ev;
        @(negedge clk);
        bus.ena = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_o("post_rst", 0, 0, 0, 0, 3);
        @(negedge clk);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conway_cell.md
# conway_cell

One Game of Life cell, sitting directly downstream of the full-adder neighbour-count logic. It sums the eight neighbour bits with a `full_adder`-based counter and applies the Conway rule on each generation strobe. It holds the cell's registered state and tracks how many generations the state has been unchanged. It also flags period-2 oscillation. A top-level grid instantiates one per cell and wires each cell's `state` into its neighbours' `neighbors` inputs.

## Interface
- `AGE_W`, default 4: width of the saturating age counter (≥2).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous assert, active-low (0 = reset).
- `ena` input 1: generation strobe; one-cycle pulse advances one generation.
- `load` input 1: synchronous preset of cell state; overrides `ena`.
- `load_value` input 1: value written to `state` when `load`=1.
- `neighbors` input 8: live bits of the eight neighbours, any order.
- `neighbor_count` output 4: combinational popcount of `neighbors`, 0..8.
- `state` output 1: registered cell state (1 = alive).
- `age` output AGE_W: generations since the last state change, saturating.
- `stable` output 1: registered; 1 when the most recent generation left `state` unchanged.
- `oscillating` output 1: registered; 1 when the last two generations both toggled `state`.

## Operation
- next = (neighbor_count==3) | (state & neighbor_count==2).
- Priority per clock edge: reset > `load` > `ena` > hold.
- `load`=1:
  - state ← load_value.
  - age ← 0; stable ← 0; oscillating ← 0.
  - Internal `changed_prev` ← 0.
- `ena`=1 and `load`=0:
  - state ← next.
  - If next==state: age ← min(age+1, 2^AGE_W−1), stable ← 1, oscillating ← 0, changed_prev ← 0.
  - If next≠state: age ← 0, stable ← 0, oscillating ← changed_prev, changed_prev ← 1.
- Neither asserted: all registers hold. `neighbor_count` still tracks inputs.
- `age` saturates at all-ones; no wrap to 0.
- `neighbors` values are sampled only on edges where `ena`=1; changes between strobes have no effect on state.

## Timing
- Reset values: state=0, age=0, stable=0, oscillating=0, changed_prev=0. Async entry; exit synchronous to the next `clk` edge after `rst` rises.
- `neighbor_count`: combinational, zero latency.
- `state`, `age`, `stable`, `oscillating`: updated on the edge where `ena` or `load` is sampled high; visible one cycle later.
- Back-to-back `ena` on every cycle is legal; each edge is one generation.
- Grid use: all cells share `ena`. Each cell reads neighbour states from before the edge, so the update is inherently synchronous.
- `load` and `ena` together: load wins, and the generation is discarded.
- Reset mid-generation (while `ena` high): reset wins immediately; no partial update.

## Configuration
- `CONWAY_CELL_AGE_EN` defined:
  - Age counter is instantiated.
  - `age` behaves as specified.
- Undefined:
  - No age register; `age` is tied to 0.
  - `stable` and `oscillating` behave identically (derived from the change flag, not from `age`).

## Structure
- Shared package `conway_pkg`:
  - `NEIGHBOR_COUNT_W` = 4.
  - Rule constants `BIRTH_COUNT` = 3 and `SURVIVE_COUNT` = 2.
  - typedef `cell_t` (1-bit logic).
- Sub-module `neighbor_counter`: 8-bit popcount built from `full_adder` instances, tree of 3:2 compressors followed by a ripple adder; purely combinational.
- `conway_cell` instantiates one `neighbor_counter` and holds all sequential logic.

## Test plan
- Reset low with arbitrary inputs -> state=0, age=0, stable=0, oscillating=0. After release with no strobe, outputs stay at 0.
- load=1, load_value=1, then ena pulse with neighbors=8'b0000_0011 -> count=2, state stays 1, age=1, stable=1.
- state=0, neighbors=8'b1010_0100, ena -> count=3, state=1, age=0, stable=0, oscillating=0.
- Alternate neighbors between 3 and 0 across four ena pulses from state=0 -> state toggles 1,0,1,0; oscillating = 0,1,1,1.
- With AGE_W=4, state=1, count held at 2 for 20 strobes -> age climbs to 15 and stays 15. With `CONWAY_CELL_AGE_EN` undefined, age stays 0 and stable=1.
- load and ena both high, load_value=0, neighbors count=3 -> state=0, all flags 0. Assert rst mid-run -> outputs clear immediately, without waiting for a `clk` edge.
